// File: rtl/data_axi_bridge_if.sv
// AXI4-Lite bus between the data-side bridge and the interconnect.
// Used unchanged with or without DBRIDGE_POSTED_WRITE_EN.
interface data_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/data_axi_bridge.sv
// Core data SRAM port to single-beat AXI4-Lite bridge, one access in flight.
// DBRIDGE_POSTED_WRITE_EN: release the core before B, hold next capture until B.
module data_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_en,
    input  logic [3:0]        req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] req_rdata,
    output logic              req_stall,
    output logic              bus_err,
    data_axi_bridge_if.master axi
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [3:0]        strb_q, strb_d;
    logic              err_q, err_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              can_cap;
    logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign ar_hs = arvalid_q & axi.arready;
    assign r_hs  = rready_q  & axi.rvalid;
    assign aw_hs = awvalid_q & axi.awready;
    assign w_hs  = wvalid_q  & axi.wready;
    assign b_hs  = bready_q  & axi.bvalid;

`ifdef DBRIDGE_POSTED_WRITE_EN
    logic b_pend_q, b_pend_d;
    assign can_cap = ~b_pend_q;
`else
    assign can_cap = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            strb_q    <= strb_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

`ifdef DBRIDGE_POSTED_WRITE_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) b_pend_q <= 1'b0;
        else         b_pend_q <= b_pend_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        strb_d    = strb_q;
        err_d     = err_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef DBRIDGE_POSTED_WRITE_EN
        b_pend_d  = b_pend_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_en && can_cap) begin
                    addr_d  = req_addr & WORD_MASK;
                    wdata_d = req_wdata;
                    strb_d  = req_wen;
                    if (req_wen == 4'b0000) begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    rdata_d  = axi.rdata;
                    err_d    = err_q | (axi.rresp != OKAY);
                    state_d  = DONE;
                end
            end
            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    bready_d = 1'b1;
`ifdef DBRIDGE_POSTED_WRITE_EN
                    b_pend_d = 1'b1;
                    state_d  = DONE;
`else
                    state_d  = WR_RESP;
`endif
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    err_d    = err_q | (axi.bresp != OKAY);
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef DBRIDGE_POSTED_WRITE_EN
        // The outstanding B retires here regardless of the current state.
        if (b_pend_q && b_hs) begin
            b_pend_d = 1'b0;
            bready_d = 1'b0;
            err_d    = err_q | (axi.bresp != OKAY);
        end
`endif
    end

    assign req_stall = resetn &
        (((state_q == IDLE) & req_en) |
         ((state_q != IDLE) & (state_q != DONE)));

    assign req_rdata   = rdata_q;
    assign bus_err     = err_q;
    assign axi.araddr  = addr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = addr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = strb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

endmodule

// File: tb/tb_data_axi_bridge.sv
// Bench for data_axi_bridge: core driver, delay-programmable AXI-Lite slave,
// expected transactions queued at stimulus and compared against slave logs.
module tb_data_axi_bridge;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          cyc;
    } hs_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } exp_t;

`ifdef DBRIDGE_POSTED_WRITE_EN
    localparam int POSTED = 1;
`else
    localparam int POSTED = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_en;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rdata;
    logic        req_stall;
    logic        bus_err;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    data_axi_bridge_if axi ();

    data_axi_bridge dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_en    (req_en),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rdata (req_rdata),
        .req_stall (req_stall),
        .bus_err   (bus_err),
        .axi       (axi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic [31:0] r_data_cfg;
    logic [1:0]  r_resp_cfg, b_resp_cfg;

    hs_t  ar_log[$], aw_log[$], w_log[$], b_log[$];
    exp_t exp_q[$];
    int   overlap = 0;

    int ar_wait, aw_wait, w_wait, r_tmr, b_tmr;
    bit r_pend, b_pend, aw_got, w_got;
    logic p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br;
    logic [31:0] p_ara, p_awa, p_wd;
    logic [3:0]  p_ws;
    int p_cyc;

    task automatic slave_clear();
        axi.arready = 0; axi.awready = 0; axi.wready = 0;
        axi.rvalid = 0; axi.bvalid = 0;
        axi.rdata = 0; axi.rresp = 0; axi.bresp = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; r_tmr = 0; b_tmr = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0; p_awv = 0;
        p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0;
        p_ara = 0; p_awa = 0; p_wd = 0; p_ws = 0; p_cyc = 0;
        ar_log.delete(); aw_log.delete(); w_log.delete(); b_log.delete();
    endtask

    // Slave acts at negedge; handshakes of the previous cycle resolved first.
    initial begin : slave
        hs_t h;
        slave_clear();
        forever begin
            @(negedge clk);
            if (!resetn) begin
                slave_clear();
                continue;
            end
            if (p_arv && p_arr) begin
                h = '{addr: p_ara, data: 0, strb: 0, cyc: p_cyc};
                ar_log.push_back(h);
                ar_wait = 0; r_pend = 1; r_tmr = r_dly;
            end
            if (p_rv && p_rr) axi.rvalid = 0;
            if (p_awv && p_awr) begin
                h = '{addr: p_awa, data: 0, strb: 0, cyc: p_cyc};
                aw_log.push_back(h);
                aw_wait = 0; aw_got = 1;
            end
            if (p_wv && p_wr) begin
                h = '{addr: 0, data: p_wd, strb: p_ws, cyc: p_cyc};
                w_log.push_back(h);
                w_wait = 0; w_got = 1;
            end
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend = 1; b_tmr = b_dly;
            end
            if (p_bv && p_br) begin
                h = '{addr: 0, data: 0, strb: 0, cyc: p_cyc};
                b_log.push_back(h);
                axi.bvalid = 0;
            end
            axi.arready = axi.arvalid && (ar_wait >= ar_dly);
            if (axi.arvalid) ar_wait++;
            axi.awready = axi.awvalid && (aw_wait >= aw_dly);
            if (axi.awvalid) aw_wait++;
            axi.wready = axi.wvalid && (w_wait >= w_dly);
            if (axi.wvalid) w_wait++;
            if (r_pend) begin
                r_tmr--;
                if (r_tmr <= 0) begin
                    axi.rvalid = 1; axi.rdata = r_data_cfg;
                    axi.rresp = r_resp_cfg; r_pend = 0;
                end
            end
            if (b_pend) begin
                b_tmr--;
                if (b_tmr <= 0) begin
                    axi.bvalid = 1; axi.bresp = b_resp_cfg; b_pend = 0;
                end
            end
            if (axi.arvalid && (axi.awvalid || axi.wvalid)) overlap++;
            p_arv = axi.arvalid; p_arr = axi.arready; p_ara = axi.araddr;
            p_rv = axi.rvalid; p_rr = axi.rready;
            p_awv = axi.awvalid; p_awr = axi.awready; p_awa = axi.awaddr;
            p_wv = axi.wvalid; p_wr = axi.wready;
            p_wd = axi.wdata; p_ws = axi.wstrb;
            p_bv = axi.bvalid; p_br = axi.bready;
            p_cyc = cyc;
        end
    end

    task automatic set_delays(int ar, int r, int aw, int w, int b);
        ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
    endtask

    task automatic clear_logs();
        ar_log.delete(); aw_log.delete(); w_log.delete(); b_log.delete();
    endtask

    task automatic idle(int n);
        @(negedge clk);
        req_en = 0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic run_access(
        input  logic [3:0]  wen,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        output int          stalls,
        output int          t0,
        output int          tdone,
        output logic [31:0] rd,
        output logic        err
    );
        @(negedge clk);
        req_en = 1; req_wen = wen; req_addr = addr; req_wdata = wd;
        t0 = cyc;
        stalls = 0;
        #1;
        while (req_stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls >= 200) begin
            n_total++;
            $display("FAIL access_timeout addr=%h stalls=%0d limit=200", addr, stalls);
        end
        tdone = cyc; rd = req_rdata; err = bus_err;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        req_en = 1; req_wen = 0; req_addr = 32'h10; req_wdata = 0;
        #1;
        n_total++; if (req_stall !== 1'b0) $display("FAIL rst_stall got=%b exp=0", req_stall); else n_pass++;
        n_total++; if (axi.arvalid !== 1'b0) $display("FAIL rst_arvalid got=%b exp=0", axi.arvalid); else n_pass++;
        n_total++; if ({axi.awvalid, axi.wvalid} !== 2'b00) $display("FAIL rst_aw_w_valid got=%b exp=00", {axi.awvalid, axi.wvalid}); else n_pass++;
        n_total++; if ({axi.bready, axi.rready} !== 2'b00) $display("FAIL rst_readies got=%b exp=00", {axi.bready, axi.rready}); else n_pass++;
        n_total++; if (req_rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", req_rdata); else n_pass++;
        n_total++; if (bus_err !== 1'b0) $display("FAIL rst_bus_err got=%b exp=0", bus_err); else n_pass++;
        n_total++; if (axi.awaddr !== 32'h0) $display("FAIL rst_awaddr got=%h exp=0", axi.awaddr); else n_pass++;
        n_total++; if ({axi.wdata, axi.wstrb} !== 36'h0) $display("FAIL rst_wdata got=%h exp=0", {axi.wdata, axi.wstrb}); else n_pass++;
        req_en = 0;
        @(negedge clk);
        resetn = 1;
        idle(2);
    endtask

    task automatic test_read_wait();
        int st, t0, td;
        logic [31:0] rd;
        logic err;
        exp_t e;
        hs_t a;
        clear_logs();
        set_delays(2, 3, 0, 0, 1);
        r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = 0;
        exp_q.push_back('{addr: 32'h1FC0_0010, data: 32'hDEAD_BEEF, strb: 4'h0});
        run_access(4'h0, 32'h1FC0_0010, 32'h0, st, t0, td, rd, err);
        idle(3);
        e = exp_q.pop_front();
        n_total++; if (st !== 7) $display("FAIL rd_stall_cycles got=%0d exp=7", st); else n_pass++;
        n_total++; if (rd !== e.data) $display("FAIL rd_data got=%h exp=%h", rd, e.data); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rd_bus_err got=%b exp=0", err); else n_pass++;
        n_total++;
        if (ar_log.size() !== 1) $display("FAIL rd_ar_count got=%0d exp=1", ar_log.size());
        else begin n_pass++; a = ar_log.pop_front(); end
        n_total++; if (a.addr !== e.addr) $display("FAIL rd_araddr got=%h exp=%h", a.addr, e.addr); else n_pass++;
    endtask

    task automatic test_write_order();
        int st, t0, td, exp_st;
        logic [31:0] rd;
        logic err;
        exp_t e;
        hs_t a, w, b;
        clear_logs();
        set_delays(0, 1, 2, 0, 1);
        exp_q.push_back('{addr: 32'h8000_0004, data: 32'h0000_1234, strb: 4'b0011});
        run_access(4'b0011, 32'h8000_0004, 32'h0000_1234, st, t0, td, rd, err);
        idle(3);
        e = exp_q.pop_front();
        exp_st = POSTED ? 4 : 5;
        n_total++; if (st !== exp_st) $display("FAIL wr_stall_cycles got=%0d exp=%0d", st, exp_st); else n_pass++;
        n_total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL wr_keeps_rdata got=%h exp=deadbeef", rd); else n_pass++;
        n_total++;
        if (aw_log.size() !== 1 || w_log.size() !== 1 || b_log.size() !== 1)
            $display("FAIL wr_hs_count got=%0d/%0d/%0d exp=1/1/1", aw_log.size(), w_log.size(), b_log.size());
        else begin
            n_pass++;
            a = aw_log.pop_front(); w = w_log.pop_front(); b = b_log.pop_front();
        end
        n_total++; if (a.addr !== e.addr) $display("FAIL wr_awaddr got=%h exp=%h", a.addr, e.addr); else n_pass++;
        n_total++; if (w.strb !== e.strb) $display("FAIL wr_wstrb got=%b exp=%b", w.strb, e.strb); else n_pass++;
        n_total++; if (w.data !== e.data) $display("FAIL wr_wdata got=%h exp=%h", w.data, e.data); else n_pass++;
        n_total++; if (a.cyc - w.cyc !== 2) $display("FAIL wr_w_before_aw got=%0d exp=2", a.cyc - w.cyc); else n_pass++;
`ifndef DBRIDGE_POSTED_WRITE_EN
        n_total++; if (td !== b.cyc + 1) $display("FAIL wr_release_after_b got=%0d exp=%0d", td, b.cyc + 1); else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        int st_r, t0_r, td_r, st_w, t0_w, td_w, exp_st;
        logic [31:0] rd_r, rd_w;
        logic err;
        exp_t er, ew;
        hs_t a, aw, w;
        clear_logs();
        set_delays(0, 1, 0, 0, 1);
        r_data_cfg = 32'h0BAD_F00D;
        exp_q.push_back('{addr: 32'h8000_0000, data: 32'h0BAD_F00D, strb: 4'h0});
        run_access(4'h0, 32'h8000_0000, 32'h0, st_r, t0_r, td_r, rd_r, err);
        exp_q.push_back('{addr: 32'h8000_0000, data: 32'hCAFE_0000, strb: 4'hF});
        run_access(4'hF, 32'h8000_0000, 32'hCAFE_0000, st_w, t0_w, td_w, rd_w, err);
        idle(3);
        er = exp_q.pop_front();
        ew = exp_q.pop_front();
        exp_st = POSTED ? 2 : 3;
        n_total++; if (st_r !== 3) $display("FAIL b2b_rd_stall got=%0d exp=3", st_r); else n_pass++;
        n_total++; if (rd_r !== er.data) $display("FAIL b2b_rd_data got=%h exp=%h", rd_r, er.data); else n_pass++;
        n_total++; if (t0_w !== td_r + 1) $display("FAIL b2b_capture_cycle got=%0d exp=%0d", t0_w, td_r + 1); else n_pass++;
        n_total++; if (st_w !== exp_st) $display("FAIL b2b_wr_stall got=%0d exp=%0d", st_w, exp_st); else n_pass++;
        n_total++; if (rd_w !== er.data) $display("FAIL b2b_rdata_held got=%h exp=%h", rd_w, er.data); else n_pass++;
        n_total++; if (overlap !== 0) $display("FAIL b2b_ar_aw_overlap got=%0d exp=0", overlap); else n_pass++;
        n_total++;
        if (ar_log.size() !== 1 || aw_log.size() !== 1 || w_log.size() !== 1)
            $display("FAIL b2b_hs_count got=%0d/%0d/%0d exp=1/1/1", ar_log.size(), aw_log.size(), w_log.size());
        else begin
            n_pass++;
            a = ar_log.pop_front(); aw = aw_log.pop_front(); w = w_log.pop_front();
        end
        n_total++; if (a.addr !== er.addr) $display("FAIL b2b_araddr got=%h exp=%h", a.addr, er.addr); else n_pass++;
        n_total++; if (aw.addr !== ew.addr) $display("FAIL b2b_awaddr got=%h exp=%h", aw.addr, ew.addr); else n_pass++;
        n_total++; if ({w.data, w.strb} !== {ew.data, ew.strb}) $display("FAIL b2b_w got=%h exp=%h", {w.data, w.strb}, {ew.data, ew.strb}); else n_pass++;
    endtask

`ifdef DBRIDGE_POSTED_WRITE_EN
    task automatic test_posted();
        int st_w, t0_w, td_w, st_r, t0_r, td_r;
        logic [31:0] rd;
        logic err;
        exp_t e;
        hs_t a, b;
        clear_logs();
        set_delays(0, 1, 0, 0, 5);
        r_data_cfg = 32'h5A5A_0001;
        run_access(4'hF, 32'h8000_0010, 32'h1111_2222, st_w, t0_w, td_w, rd, err);
        exp_q.push_back('{addr: 32'h8000_0020, data: 32'h5A5A_0001, strb: 4'h0});
        run_access(4'h0, 32'h8000_0020, 32'h0, st_r, t0_r, td_r, rd, err);
        idle(3);
        e = exp_q.pop_front();
        n_total++; if (st_w !== 2) $display("FAIL post_wr_stall got=%0d exp=2", st_w); else n_pass++;
        n_total++; if (st_r !== 7) $display("FAIL post_rd_stall got=%0d exp=7", st_r); else n_pass++;
        n_total++; if (rd !== e.data) $display("FAIL post_rd_data got=%h exp=%h", rd, e.data); else n_pass++;
        n_total++;
        if (ar_log.size() !== 1 || b_log.size() !== 1)
            $display("FAIL post_hs_count got=%0d/%0d exp=1/1", ar_log.size(), b_log.size());
        else begin
            n_pass++;
            a = ar_log.pop_front(); b = b_log.pop_front();
        end
        n_total++; if (a.cyc <= b.cyc) $display("FAIL post_ar_after_b got_ar=%0d b=%0d exp ar>b", a.cyc, b.cyc); else n_pass++;
    endtask
`endif

    task automatic test_bus_err();
        int st, t0, td;
        logic [31:0] rd;
        logic err;
        logic [3:0] wen;
        exp_t e;
        clear_logs();
        set_delays(0, 1, 0, 0, 1);
        r_data_cfg = 32'h0; r_resp_cfg = 2'b10;
        run_access(4'h0, 32'h8000_0100, 32'h0, st, t0, td, rd, err);
        r_resp_cfg = 2'b00;
        n_total++; if (err !== 1'b1) $display("FAIL err_set got=%b exp=1", err); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            wen = (i % 2 == 1) ? 4'hF : 4'h0;
            r_data_cfg = 32'h1000_0000 + i;
            if (wen == 4'h0)
                exp_q.push_back('{addr: 32'h200 + 4 * i, data: 32'h1000_0000 + i, strb: 4'h0});
            run_access(wen, 32'h200 + 4 * i, 32'hA0 + i, st, t0, td, rd, err);
            n_total++; if (err !== 1'b1) $display("FAIL err_sticky_%0d got=%b exp=1", i, err); else n_pass++;
            if (wen == 4'h0) begin
                e = exp_q.pop_front();
                n_total++; if (rd !== e.data) $display("FAIL err_rd_%0d got=%h exp=%h", i, rd, e.data); else n_pass++;
            end
        end
        idle(3);
    endtask

    task automatic test_reset_mid();
        int st, t0, td;
        logic [31:0] rd;
        logic err;
        bit seen;
        exp_t e;
        hs_t a;
        clear_logs();
        set_delays(0, 6, 0, 0, 1);
        @(negedge clk);
        req_en = 1; req_wen = 0; req_addr = 32'h8000_0080; req_wdata = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (axi.rready) begin
                seen = 1;
                break;
            end
        end
        n_total++; if (seen !== 1'b1) $display("FAIL mid_reached_rd_data got=%b exp=1", seen); else n_pass++;
        resetn = 0;
        req_en = 0;
        #1;
        n_total++; if (axi.rready !== 1'b0) $display("FAIL mid_rready got=%b exp=0", axi.rready); else n_pass++;
        n_total++; if ({axi.arvalid, axi.awvalid, axi.wvalid} !== 3'b000) $display("FAIL mid_valids got=%b exp=000", {axi.arvalid, axi.awvalid, axi.wvalid}); else n_pass++;
        n_total++; if (bus_err !== 1'b0) $display("FAIL mid_bus_err got=%b exp=0", bus_err); else n_pass++;
        n_total++; if (req_stall !== 1'b0) $display("FAIL mid_stall got=%b exp=0", req_stall); else n_pass++;
        repeat (2) @(negedge clk);
        resetn = 1;
        idle(2);
        set_delays(0, 1, 0, 0, 1);
        r_data_cfg = 32'h1234_5678;
        exp_q.push_back('{addr: 32'h0000_0040, data: 32'h1234_5678, strb: 4'h0});
        run_access(4'h0, 32'h0000_0040, 32'h0, st, t0, td, rd, err);
        idle(3);
        e = exp_q.pop_front();
        n_total++; if (st !== 3) $display("FAIL post_rst_stall got=%0d exp=3", st); else n_pass++;
        n_total++; if (rd !== e.data) $display("FAIL post_rst_rdata got=%h exp=%h", rd, e.data); else n_pass++;
        n_total++;
        if (ar_log.size() !== 1) $display("FAIL post_rst_ar_count got=%0d exp=1", ar_log.size());
        else begin n_pass++; a = ar_log.pop_front(); end
        n_total++; if (a.addr !== e.addr) $display("FAIL post_rst_araddr got=%h exp=%h", a.addr, e.addr); else n_pass++;
    endtask

    initial begin
        req_en = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
        set_delays(0, 1, 0, 0, 1);
        r_data_cfg = 0; r_resp_cfg = 0; b_resp_cfg = 0;
        test_reset();
        test_read_wait();
        test_write_order();
        test_back_to_back();
`ifdef DBRIDGE_POSTED_WRITE_EN
        test_posted();
`endif
        test_bus_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
